overlay_fetch: RTL and testbench
================================

Name: overlay_fetch

Overview:
- Streams the overlay RGBA image from the SDRAM read channel into the display pipeline, one 16-bit pixel per active pixel slot.
- Sits between the sdram channel-1 read port and the overlay blend / alpha stage.
- Resynchronises to the start of each frame on the VSync rising edge.
- Prefetches 32-bit words into a small FIFO so that SDRAM latency never stalls the pixel stream.

Parameters:
- FIFO_DEPTH, 4: FIFO depth in 32-bit words; must be a power of two and at least 2.
- RD_LAT, 2: clock cycles from the mem_req pulse to valid mem_dout; fixed, at least 1.
- BASE_ADDR, 24'h0: halfword address of the first overlay pixel in each frame.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  synchronous, active-high.
- enable  in  1  overlay present and not downloading; low forces idle and black output.
- ce_pix  in  1  pixel clock enable.
- de  in  1  display active, equal to ~(hblank|vblank).
- vs  in  1  vertical sync; its rising edge starts a new frame.
- mem_addr  out  24  halfword address [24:1] for the read; always even (word aligned).
- mem_req  out  1  one-clock read request pulse.
- mem_dout  in  32  read data, valid exactly RD_LAT clocks after mem_req.
- bg_r, bg_g, bg_b, bg_a  out  4 each  current overlay pixel.
- underflow  out  1  sticky per frame: a pixel was needed while the FIFO was empty.

Behaviour:
- Reset values: mem_req=0, mem_addr=BASE_ADDR, all bg_* outputs=0, underflow=0, FIFO empty, halfword select=0, FSM in IDLE.
- Pixel format: a halfword h maps to r=h[3:0], g=h[7:4], b=h[11:8], a=h[15:12].
- Word order: within a word, mem_dout[15:0] is output first, then mem_dout[31:16].
- vs rising-edge detect: registered old_vs; an edge is vs & ~old_vs.
- FSM states:
  - IDLE → REQ when enable, no pending flush, and (fifo_count + outstanding) < FIFO_DEPTH.
  - REQ: drive mem_req=1 for exactly one clock, then go to WAIT.
  - WAIT: count RD_LAT clocks. On the last one, push mem_dout into the FIFO unless the request is marked discard. Then go to IDLE and advance mem_addr by 2.
  - Only one request is ever outstanding.
- Frame start (vs edge, enable high), all in the same clock:
  - FIFO cleared, halfword select=0, mem_addr=BASE_ADDR, underflow cleared.
  - If the FSM is in WAIT, the in-flight request is marked discard: its data is dropped and mem_addr is not advanced.
  - If the FSM is in REQ, the pulse completes and that request is also discarded.
- Prefetch during vblank fills the FIFO to FIFO_DEPTH words before de rises.
- Pixel consumption: on ce_pix & de:
  - If the FIFO is not empty, bg_* ← the selected halfword of the FIFO head and halfword select toggles. When select was 1, the head word pops.
  - If the FIFO is empty, bg_* ← 0, underflow ← 1, halfword select is unchanged.
- Outputs hold their value when ce_pix=0 or de=0.
- Simultaneous push and pop in one clock are both honoured; fifo_count is unchanged.
- Push into a full FIFO cannot occur because of the request rule; any such event is a design bug and must be flagged by a bench assertion.
- mem_addr wraps modulo 2^24 with no special handling.
- enable low: FSM returns to IDLE, any in-flight data is discarded, FIFO is cleared, bg_*=0, mem_req=0, mem_addr=BASE_ADDR.
- Reset mid-request: everything returns to reset values on the next clock, with no further mem_req.
- Output latency: the pixel appears on bg_* one clock after the qualifying ce_pix & de.

Optional Feature:
- Macro OVERLAY_FETCH_STATS_EN adds two outputs:
  - underflow_cnt[15:0]: saturating count of underflow pixels, cleared on each vs edge, value captured into last_underflow_cnt first.
  - last_underflow_cnt[15:0]: the previous frame's underflow count.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, enable=1, pulse vs, memory model returns word 0x22221111 at word 0 and 0x44443333 at word 1. With ce_pix every other clock and de=1: bg_* outputs halfwords 0x1111, 0x2222, 0x3333, 0x4444 in that order; mem_addr goes 0, 2, 4, …; underflow stays 0.
- Hold de=0 after vs with RD_LAT=2 → exactly FIFO_DEPTH=4 mem_req pulses, then no further requests until pixels are consumed.
- Memory model with RD_LAT=2, ce_pix every clock, de=1 continuously → FIFO drains, bg_*=0 on the starved pixel, underflow=1, held until the next vs edge clears it.
- Assert a vs edge during WAIT with in-flight data 0xDEADBEEF → that data never appears on bg_*; the next mem_req addresses BASE_ADDR; the first pixel equals the halfword at BASE_ADDR.
- Drop enable mid-line → on the next clock bg_*=0, mem_req=0, FIFO empty. Re-enable and pulse vs → the stream restarts from pixel 0.
- With OVERLAY_FETCH_STATS_EN, starve 5 pixels in a frame, then pulse vs → last_underflow_cnt=5 and underflow_cnt=0.

Source files
------------

// File: rtl/overlay_fetch.sv
// Overlay fetch: streams 16-bit RGBA overlay pixels from the SDRAM read channel into the display pipeline.
// Latency: a pixel appears on bg_* one clock after the qualifying ce_pix & de; each read takes 1 + RD_LAT + 1 clocks.
// Backpressure: reads are issued only while the FIFO has room, one at a time; an empty FIFO yields black pixels and sets underflow.
//
// Ports: clk/reset (sync, active-high); enable, ce_pix, de, vs from the video timing;
//        mem_addr/mem_req/mem_dout to the SDRAM read channel (data valid RD_LAT clocks after mem_req);
//        bg_r/g/b/a current overlay pixel; underflow sticky per frame.
// Optional macro OVERLAY_FETCH_STATS_EN adds underflow_cnt / last_underflow_cnt per-frame starvation counters.
module overlay_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          RD_LAT     = 2,
    parameter logic [23:0] BASE_ADDR  = 24'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ce_pix,
    input  logic        de,
    input  logic        vs,
    output logic [23:0] mem_addr,
    output logic        mem_req,
    input  logic [31:0] mem_dout,
    output logic [3:0]  bg_r,
    output logic [3:0]  bg_g,
    output logic [3:0]  bg_b,
    output logic [3:0]  bg_a,
    output logic        underflow
`ifdef OVERLAY_FETCH_STATS_EN
    ,
    output logic [15:0] underflow_cnt,
    output logic [15:0] last_underflow_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            discard_q, discard_d;
    logic            old_vs_q;
    logic [23:0]     addr_q, addr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic [15:0]     pix_q, pix_d;
    logic            under_q, under_d;
    logic [31:0]     fifo_mem_q [FIFO_DEPTH];

    logic            vs_edge;
    logic            frame_start;
    logic            consume;
    logic            fifo_empty;
    logic            wait_last;
    logic            push;
    logic            pop;
    logic            starve;
    logic [31:0]     head;

    assign vs_edge     = vs & ~old_vs_q;
    assign frame_start = vs_edge & enable;
    // A frame restart takes the whole clock: no pixel is consumed alongside it.
    assign consume     = enable & ce_pix & de & ~frame_start;
    assign fifo_empty  = (cnt_q == '0);
    assign head        = fifo_mem_q[rd_ptr_q];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Only IDLE issues a read, so at most one is outstanding and the
    // room check reduces to cnt_q < FIFO_DEPTH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable && !frame_start && (cnt_q < CW'(FIFO_DEPTH))) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (wait_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (!enable) state_d = ST_IDLE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_req   = (state_q == ST_REQ);
        wait_last = (state_q == ST_WAIT) && (lat_q == LAT_LAST);
    end

    // ---------------- datapath ----------------
    always_comb begin
        lat_d = '0;
        if (enable && (state_q == ST_WAIT) && !wait_last) lat_d = lat_q + LW'(1);

        // A frame restart while a read is in flight poisons that read; the
        // tag lives until its data slot has passed.
        discard_d = 1'b0;
        if (enable) begin
            if (state_q == ST_REQ) begin
                discard_d = frame_start;
            end else if ((state_q == ST_WAIT) && !wait_last) begin
                discard_d = discard_q | frame_start;
            end
        end

        push   = wait_last & enable & ~discard_q & ~frame_start;
        starve = consume & fifo_empty;
        pop    = consume & ~fifo_empty & sel_q;

        addr_d = addr_q;
        if (!enable || frame_start) begin
            addr_d = BASE_ADDR;
        end else if (wait_last && !discard_q) begin
            addr_d = addr_q + 24'd2;
        end

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CW'(1);
        if (pop && !push) cnt_d = cnt_q - CW'(1);

        sel_d   = sel_q;
        pix_d   = pix_q;
        under_d = under_q;
        if (starve) begin
            pix_d   = '0;
            under_d = 1'b1;
        end else if (consume) begin
            pix_d = sel_q ? head[31:16] : head[15:0];
            sel_d = ~sel_q;
        end

        if (frame_start || !enable) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            sel_d    = 1'b0;
        end
        if (frame_start) under_d = 1'b0;
        if (!enable)     pix_d   = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q     <= '0;
            discard_q <= 1'b0;
            old_vs_q  <= 1'b0;
            addr_q    <= BASE_ADDR;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            pix_q     <= '0;
            under_q   <= 1'b0;
        end else begin
            lat_q     <= lat_d;
            discard_q <= discard_d;
            old_vs_q  <= vs;
            addr_q    <= addr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            pix_q     <= pix_d;
            under_q   <= under_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= mem_dout;
    end

    assign mem_addr  = addr_q;
    assign bg_r      = pix_q[3:0];
    assign bg_g      = pix_q[7:4];
    assign bg_b      = pix_q[11:8];
    assign bg_a      = pix_q[15:12];
    assign underflow = under_q;

`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;
    logic [15:0] last_q, last_d;

    always_comb begin
        ucnt_d = ucnt_q;
        last_d = last_q;
        if (vs_edge) begin
            last_d = ucnt_q;
            ucnt_d = '0;
        end else if (starve && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ucnt_q <= '0;
            last_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
            last_q <= last_d;
        end
    end

    assign underflow_cnt      = ucnt_q;
    assign last_underflow_cnt = last_q;
`endif

endmodule

// File: tb/tb_overlay_fetch.sv
module tb_overlay_fetch;

    localparam int          RD_LAT = 2;
    localparam int          DEPTH  = 4;
    localparam logic [23:0] BASE   = 24'h0;

    logic        clk = 1'b0;
    logic        reset, enable, ce_pix, de, vs;
    logic [23:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_dout;
    logic [3:0]  bg_r, bg_g, bg_b, bg_a;
    logic        underflow;
`ifdef OVERLAY_FETCH_STATS_EN
    logic [15:0] underflow_cnt, last_underflow_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    overlay_fetch #(.FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ce_pix(ce_pix), .de(de), .vs(vs),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_dout(mem_dout),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_a(bg_a),
`ifdef OVERLAY_FETCH_STATS_EN
        .underflow_cnt(underflow_cnt), .last_underflow_cnt(last_underflow_cnt),
`endif
        .underflow(underflow)
    );

    // Overlay image: halfword h holds 0x1111 * ((h mod 15) + 1), never zero,
    // so a zero pixel on bg_* can only mean a starved slot.
    function automatic logic [15:0] half_val(input logic [23:0] h);
        logic [31:0] t;
        t = 32'h1111 * (32'(h % 24'd15) + 32'd1);
        return t[15:0];
    endfunction

    // SDRAM read model: fixed RD_LAT pipeline; poison replaces the data with DEADBEEF.
    logic        poison;
    logic [31:0] pipe [RD_LAT];
    always @(posedge clk) begin
        for (int k = RD_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= !mem_req ? 32'h0 :
                   poison   ? 32'hDEADBEEF :
                   {half_val(mem_addr + 24'd1), half_val(mem_addr)};
    end
    assign mem_dout = pipe[RD_LAT-1];

    wire [15:0] bg = {bg_a, bg_b, bg_g, bg_r};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus changes at +2 after the edge; the monitor samples at +1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model of the pixel stream: within a frame the non-black
    // pixels must be the image halfwords BASE, BASE+1, ... in order.
    int          mk;
    logic        m_under, m_old_vs;
    logic [15:0] m_bg;
    initial begin
        logic r, e, c, d, v, fs;
        mk = 0; m_under = 0; m_old_vs = 0; m_bg = 0;
        forever begin
            @(posedge clk);
            r = reset; e = enable; c = ce_pix; d = de; v = vs;
            #1;
            if (r) begin
                check("rst_bg", 32'(bg), 0);
                check("rst_req", 32'(mem_req), 0);
                check("rst_addr", 32'(mem_addr), 32'(BASE));
                mk = 0; m_under = 0; m_old_vs = 0; m_bg = 0;
            end else begin
                fs = e & v & ~m_old_vs;
                m_old_vs = v;
                if (!e) begin
                    check("dis_bg", 32'(bg), 0);
                    m_bg = 0; mk = 0;
                end else if (fs) begin
                    check("fs_hold", 32'(bg), 32'(m_bg));
                    mk = 0; m_under = 0;
                end else if (c && d) begin
                    if (bg == 16'h0) begin
                        m_under = 1; m_bg = 0;
                    end else begin
                        check("pix", 32'(bg), 32'(half_val(BASE + 24'(mk))));
                        m_bg = half_val(BASE + 24'(mk));
                        mk++;
                    end
                end else begin
                    check("hold", 32'(bg), 32'(m_bg));
                end
                check("addr_even", 32'(mem_addr[0]), 0);
                check("push_full", 32'(dut.push && (dut.cnt_q == 3'(DEPTH))), 0);
            end
            check("under", 32'(underflow), 32'(m_under));
        end
    end

    typedef struct {
        logic        ce;
        logic        de;
        logic [15:0] bg;
    } vec_t;

    initial begin
        vec_t tbl [12];
        int   nreq;
        logic ok;

        tbl[0]  = '{1'b1, 1'b1, 16'h1111};
        tbl[1]  = '{1'b0, 1'b1, 16'h1111};
        tbl[2]  = '{1'b1, 1'b1, 16'h2222};
        tbl[3]  = '{1'b0, 1'b1, 16'h2222};
        tbl[4]  = '{1'b1, 1'b1, 16'h3333};
        tbl[5]  = '{1'b0, 1'b1, 16'h3333};
        tbl[6]  = '{1'b1, 1'b1, 16'h4444};
        tbl[7]  = '{1'b0, 1'b0, 16'h4444};
        tbl[8]  = '{1'b1, 1'b0, 16'h4444};
        tbl[9]  = '{1'b1, 1'b1, 16'h5555};
        tbl[10] = '{1'b0, 1'b1, 16'h5555};
        tbl[11] = '{1'b1, 1'b1, 16'h6666};

        reset = 1; enable = 1; ce_pix = 0; de = 0; vs = 0; poison = 0;
        tick(); tick();
        check("reset_under", 32'(underflow), 0);
        reset = 0;
        repeat (3) tick();

        // Frame start with de low: exactly DEPTH reads at 0,2,4,6, then quiet.
        vs = 1; tick(); vs = 0;
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req) begin
                check("pref_addr", 32'(mem_addr), 32'(BASE) + 32'(2 * nreq));
                nreq++;
            end
            tick();
        end
        check("pref_reqs", 32'(nreq), 32'(DEPTH));
        check("pref_addr_end", 32'(mem_addr), 32'(BASE) + 32'(2 * DEPTH));

        for (int i = 0; i < 12; i++) begin
            ce_pix = tbl[i].ce; de = tbl[i].de;
            tick();
            check("tbl_bg", 32'(bg), 32'(tbl[i].bg));
            check("tbl_under", 32'(underflow), 0);
        end

        // Starvation: one pixel per clock outruns the fetch.
        ce_pix = 1; de = 1; ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick();
            if (underflow) begin
                ok = 1;
                check("starve_bg", 32'(bg), 0);
            end
        end
        check("starve_seen", 32'(ok), 1);
        repeat (10) tick();
        check("under_sticky", 32'(underflow), 1);
        ce_pix = 0; de = 0; vs = 1; tick(); vs = 0;
        check("under_clr", 32'(underflow), 0);

        // Frame start while the read returning DEADBEEF is in flight.
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req) ok = 1; else tick();
        end
        check("disc_req_seen", 32'(ok), 1);
        poison = 1; tick();
        poison = 0; vs = 1; tick(); vs = 0;
        check("disc_addr", 32'(mem_addr), 32'(BASE));
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (mem_req) ok = 1;
        end
        check("disc_next_req", 32'(ok), 1);
        check("disc_next_addr", 32'(mem_addr), 32'(BASE));
        repeat (40) tick();
        ce_pix = 1; de = 1; tick();
        check("disc_pix0", 32'(bg), 32'(half_val(BASE)));
        ce_pix = 0; tick();
        ce_pix = 1; tick();
        check("disc_pix1", 32'(bg), 32'(half_val(BASE + 24'd1)));

        // Enable dropped mid-line, then restart.
        tick(); tick();
        enable = 0; tick();
        check("dis_bg0", 32'(bg), 0);
        check("dis_req", 32'(mem_req), 0);
        check("dis_addr", 32'(mem_addr), 32'(BASE));
        check("dis_fifo", 32'(dut.cnt_q), 0);
        ce_pix = 0; de = 0; tick();
        enable = 1; vs = 1; tick(); vs = 0;
        repeat (40) tick();
        ce_pix = 1; de = 1; tick();
        check("ren_pix0", 32'(bg), 32'h1111);
        tick();
        check("ren_pix1", 32'(bg), 32'h2222);
        ce_pix = 0; de = 0; tick();

        // Reset while a read is being issued.
        ce_pix = 1; de = 1; ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (mem_req) ok = 1; else tick();
        end
        check("rstmid_req_seen", 32'(ok), 1);
        reset = 1; ce_pix = 0; de = 0; tick();
        check("rstmid_req", 32'(mem_req), 0);
        check("rstmid_bg", 32'(bg), 0);
        tick();
        check("rstmid_req2", 32'(mem_req), 0);
        reset = 0;

`ifdef OVERLAY_FETCH_STATS_EN
        // FIFO full and idle, then frame start with a pixel every clock for
        // seven clocks: slots 1-4 and 7 starve.
        vs = 1; tick(); vs = 0;
        repeat (40) tick();
        vs = 1; tick(); vs = 0;
        ce_pix = 1; de = 1;
        repeat (7) tick();
        ce_pix = 0; de = 0; tick();
        check("stat_cnt", 32'(underflow_cnt), 5);
        vs = 1; tick(); vs = 0;
        check("stat_last", 32'(last_underflow_cnt), 5);
        check("stat_clr", 32'(underflow_cnt), 0);
`endif

        // Random traffic against the stream model.
        for (int i = 0; i < 3000; i++) begin
            ce_pix = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 40) == 0) de = ~de;
            vs     = ($urandom_range(0, 250) == 0);
            enable = ($urandom_range(0, 400) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
